// File: rtl/uart_rxd_if.sv
// rtl/uart_rxd_if.sv - serial line and received-byte bundle for uart_rxd
// Signals:
//   rxd        serial line, idle high (driven by the line side)
//   q          last correctly received byte
//   valid      one-clock pulse, q updated in the same cycle
//   frame_err  one-clock pulse when a stop bit is sampled low
//   busy       receiver is inside a frame or waiting for the line to idle
// Modports: master = receiver, slave = line driver / byte consumer.
interface uart_rxd_if;
    logic       rxd;
    logic [7:0] q;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rxd,
        output q,
        output valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rxd,
        input  q,
        input  valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rxd.sv
// rtl/uart_rxd.sv - UART receiver, 8 data bits, no parity, 1 stop bit, MSB first
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    uart_rxd_if.master: rxd in; q, valid, frame_err, busy out
module uart_rxd #(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE       = 115_200
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rxd_if.master    bus
);
    localparam int DIV  = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state, state_n;
    logic          sync1, rxd_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    q_r, q_n;
    logic          valid_r, valid_n;
    logic          ferr_r, ferr_n;

    // Two-flop synchroniser; reset to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= bus.rxd;
            rxd_s <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            q_r     <= '0;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            q_r     <= q_n;
            valid_r <= valid_n;
            ferr_r  <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        q_n       = q_r;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxd_s) state_n = START;
            end
            START: begin
                // Mid start bit: a high line here means the low was only a glitch.
                if (cnt == CNT_HALF) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_FULL) begin
                    cnt_n     = '0;
                    shift_n   = {shift[6:0], rxd_s};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is caught in IDLE.
                if (cnt == CNT_FULL) begin
                    cnt_n = '0;
                    if (rxd_s) begin
                        q_n     = shift;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // A held-low line (break) must not be read as a stream of frames.
                cnt_n = '0;
                if (rxd_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.q         = q_r;
    assign bus.valid     = valid_r;
    assign bus.frame_err = ferr_r;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_rxd.sv
// tb/tb_uart_rxd.sv - self-checking bench for uart_rxd
module tb_uart_rxd;
    localparam int DIV = 16;

    logic clk;
    logic rst_n;
    uart_rxd_if bus ();

    uart_rxd #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int vcnt   = 0;
    int fcnt   = 0;
    int last_valid_cyc = 0;
    bit overlap  = 0;
    bit watch_idle = 0;
    bit idle_bad = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.valid) begin
            vcnt++;
            last_valid_cyc = cyc;
        end
        if (bus.frame_err) fcnt++;
        if (bus.valid && bus.frame_err) overlap = 1;
        if (watch_idle && (bus.valid || bus.frame_err || bus.busy || bus.q != 8'h00))
            idle_bad = 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic send_bits(input logic v, input int n);
        bus.rxd = v;
        repeat (n) @(negedge clk);
    endtask

    int start_cyc;

    task automatic send_frame(input logic [7:0] d, input logic stop);
        start_cyc = cyc;
        send_bits(1'b0, DIV);
        for (int i = 7; i >= 0; i--) send_bits(d[i], DIV);
        send_bits(stop, DIV);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap_bits;
        logic [7:0] exp_q;
        int         exp_v;
        int         exp_fe;
    } vec_t;

    vec_t vecs[5];
    logic [7:0] model_q;

    task automatic run_frame(input string tag, input logic [7:0] d, input logic stop,
                             input int gap, input logic [7:0] exp_q,
                             input int exp_v, input int exp_fe);
        int v0, f0;
        v0 = vcnt;
        f0 = fcnt;
        send_frame(d, stop);
        send_bits(1'b1, gap * DIV);
        chk({tag, "_valid_cnt"}, vcnt - v0, exp_v);
        chk({tag, "_ferr_cnt"}, fcnt - f0, exp_fe);
        chk({tag, "_q"}, bus.q, exp_q);
        if (gap > 0) chk({tag, "_busy_idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        int v0, f0;
        logic [7:0] d;
        logic       stop;
        int         gap;

        vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 0, 8'h00, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 1, 0};
        vecs[3] = '{8'h3C, 1'b0, 1, 8'hFF, 0, 1};
        vecs[4] = '{8'h81, 1'b1, 1, 8'h81, 1, 0};

        bus.rxd = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_q", bus.q, 8'h00);
        chk("reset_busy", bus.busy, 1'b0);
        rst_n = 1'b1;

        // Idle line: nothing may move.
        watch_idle = 1;
        repeat (100) @(negedge clk);
        watch_idle = 0;
        chk("idle_quiet", idle_bad, 1'b0);

        // Table vectors: single frame, back-to-back, stop error, recovery.
        for (int i = 0; i < 5; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].stop, vecs[i].gap_bits,
                      vecs[i].exp_q, vecs[i].exp_v, vecs[i].exp_fe);
            if (i == 0) begin
                // Nominal 2 + HALF + 9*DIV = 154 clocks from the start edge.
                chk("latency_a5", (last_valid_cyc - start_cyc >= 152) &&
                                  (last_valid_cyc - start_cyc <= 156), 1'b1);
            end
        end
        model_q = 8'h81;

        // Short glitch on the line.
        v0 = vcnt; f0 = fcnt;
        send_bits(1'b0, 4);
        send_bits(1'b1, 12);
        chk("glitch_busy", bus.busy, 1'b0);
        chk("glitch_pulses", (vcnt - v0) + (fcnt - f0), 0);

        // Frame then break of 20 bit times.
        v0 = vcnt; f0 = fcnt;
        send_frame(8'h3C, 1'b0);
        send_bits(1'b0, 20 * DIV);
        chk("break_ferr", fcnt - f0, 1);
        chk("break_valid", vcnt - v0, 0);
        chk("break_busy", bus.busy, 1'b1);
        chk("break_q", bus.q, model_q);
        send_bits(1'b1, 8);
        chk("break_release", bus.busy, 1'b0);
        run_frame("after_break", 8'h81, 1'b1, 1, 8'h81, 1, 0);

        // Asynchronous reset in the middle of the 4th data bit.
        v0 = vcnt; f0 = fcnt;
        send_bits(1'b0, DIV);
        send_bits(1'b0, DIV);
        send_bits(1'b1, DIV);
        send_bits(1'b0, DIV);
        send_bits(1'b1, DIV / 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_q", bus.q, 8'h00);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_valid", bus.valid, 1'b0);
        chk("midrst_ferr", bus.frame_err, 1'b0);
        @(negedge clk);
        bus.rxd = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        send_bits(1'b1, 12 * DIV);
        chk("midrst_pulses", (vcnt - v0) + (fcnt - f0), 0);
        run_frame("post_rst", 8'h5A, 1'b1, 1, 8'h5A, 1, 0);
        model_q = 8'h5A;

        // Loopback-style byte stream.
        run_frame("lb0", 8'h00, 1'b1, 0, 8'h00, 1, 0);
        run_frame("lb1", 8'h55, 1'b1, 0, 8'h55, 1, 0);
        run_frame("lb2", 8'hAA, 1'b1, 0, 8'hAA, 1, 0);
        run_frame("lb3", 8'hFF, 1'b1, 0, 8'hFF, 1, 0);
        run_frame("lb4", 8'h12, 1'b1, 1, 8'h12, 1, 0);
        model_q = 8'h12;

        // Random frames against the reference: q is the last byte whose stop bit was high.
        for (int i = 0; i < 24; i++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            if (i == 23) gap = 1;
            if (stop) model_q = d;
            run_frame($sformatf("rnd%0d", i), d, stop, gap, model_q,
                      stop ? 1 : 0, stop ? 0 : 1);
        end

        chk("no_overlap", overlap, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_rxd.md
Name: uart_rxd

Overview:
- UART receiver: 8 data bits, no parity, 1 stop bit, MSB first.
- Pairs with the team's uart_txd at the far end of a serial link, using the same CLOCK_FREQUENCY/BAUD_RATE parameterisation.
- Synchronises the asynchronous rxd line, finds the start bit, samples each bit at mid-period, and presents each byte with a one-cycle valid pulse. Framing errors are flagged.

Parameters:
- CLOCK_FREQUENCY, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, line bit rate in bits/s.
- Derived, not overridable: DIV = CLOCK_FREQUENCY/BAUD_RATE (integer division), clocks per bit. HALF = DIV/2.
- DIV must be >= 4. The baud counter is sized to hold DIV-1.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rxd  input  1  serial line, idle high, asynchronous to clk.
- q  output  8  last correctly received byte. Held until the next good frame.
- valid  output  1  one-clock pulse; q is updated in the same cycle.
- frame_err  output  1  one-clock pulse when the stop bit is sampled as 0.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: q=8'h00, valid=0, frame_err=0, busy=0, FSM=IDLE, both synchroniser flops=1, baud counter=0, bit index=0, shift register=0.
- Reset is asynchronous, including in mid-frame. The partial frame is discarded with no pulses.
- Synchroniser: rxd passes through 2 flops to give rxd_s. All decisions use rxd_s only. This adds 2 cycles of latency.
- IDLE:
  - rxd_s==0 -> START, baud counter cleared.
- START:
  - Counter runs 0..HALF-1.
  - At HALF-1, rxd_s is sampled. If 0 -> DATA, counter=0, bit index=0. If 1 it was a glitch -> IDLE, no pulses.
- DATA:
  - Counter runs 0..DIV-1, then wraps to 0.
  - At each DIV-1: shift <= {shift[6:0], rxd_s} and the bit index increments.
  - After the 8th sample -> STOP.
  - The first bit received becomes q[7].
- STOP:
  - At counter DIV-1, rxd_s is sampled.
  - If 1: q <= shift, valid=1 for the next cycle, -> IDLE. The FSM returns to IDLE at mid-stop-bit so it can resynchronise on a back-to-back start.
  - If 0: frame_err=1 for the next cycle, q unchanged, -> WAIT_IDLE.
- WAIT_IDLE:
  - Stays until rxd_s==1, then -> IDLE. A break condition therefore produces exactly one frame_err and no spurious frames.
- valid and frame_err are registered and never both high. Each asserts for exactly 1 clock per frame.
- Latency: the valid pulse occurs 2 + HALF + 9*DIV (±2) clocks after the rxd falling edge of the start bit.
- busy is high in START, DATA, STOP and WAIT_IDLE.
- Zero idle time between frames is supported. Sender and receiver clock mismatch is tolerated up to ±(HALF-2)/(10*DIV) per frame.

Test Plan:
(All tests use CLOCK_FREQUENCY=16, BAUD_RATE=1, so DIV=16, HALF=8, unless stated.)
1. Reset with rxd=1, then 100 idle clocks -> q=8'h00, valid=0, frame_err=0, busy=0 throughout.
2. Frame 0xA5 sent MSB first (start 0; data 1,0,1,0,0,1,0,1; stop 1), 16 clocks per bit -> exactly one valid pulse, q=8'hA5, valid about 154 clocks after the start edge, frame_err=0, busy low after the pulse.
3. Back-to-back 0x00 then 0xFF with no idle gap -> two valid pulses with q=8'h00 then q=8'hFF, no frame_err.
4. Glitch and break:
   - rxd low for 4 clocks -> no pulses, busy returns to 0 within 12 clocks.
   - Then 0x3C followed by the line held low for 20 bit times -> one frame_err pulse, q keeps its previous value, busy stays 1 until rxd returns high.
   - Then frame 0x81 -> q=8'h81.
5. rst_n pulsed low during the 4th data bit -> all outputs reset immediately, no pulse for the partial frame. The next full frame 0x5A -> q=8'h5A.
6. Loopback at default parameters: uart_txd output drives rxd, bytes 0x00, 0x55, 0xAA, 0xFF, 0x12 sent -> each received in order with valid, no frame_err.
